// File: rtl/teclado_clave_if.sv
// -----------------------------------------------------------------------------
// teclado_clave_if
// Bundle between the keypad scanner / access controller and the keypad front
// end teclado_clave.
//   Tecla        [3:0]  key code from the scanner (0-9 digit, A Borrar,
//                       B Confirmar, C-F invalid)
//   TeclaValida         high while a key is pressed (may bounce)
//   Clave        [15:0] last confirmed BCD password, first digit in [15:12]
//   Enter               one-cycle pulse: Clave newly valid
//   ErrorEntrada        one-cycle pulse: rejected key or discarded entry
//   Digitos      [2:0]  digits currently buffered (0-4)
// Modports: master = scanner/controller side, slave = teclado_clave.
// -----------------------------------------------------------------------------
interface teclado_clave_if;
  logic [3:0]  Tecla;
  logic        TeclaValida;
  logic [15:0] Clave;
  logic        Enter;
  logic        ErrorEntrada;
  logic [2:0]  Digitos;

  modport master (
    output Tecla, TeclaValida,
    input  Clave, Enter, ErrorEntrada, Digitos
  );

  modport slave (
    input  Tecla, TeclaValida,
    output Clave, Enter, ErrorEntrada, Digitos
  );
endinterface

// File: rtl/teclado_clave.sv
// -----------------------------------------------------------------------------
// teclado_clave
// Keypad front end: debounces key strobes, assembles four BCD digits and
// presents the confirmed password with a one-cycle Enter pulse. Malformed or
// abandoned entries raise a one-cycle ErrorEntrada pulse instead.
// Parameters:
//   DEBOUNCE  stable sampled cycles needed for press and for release (>=1)
//   TIMEOUT   idle cycles after the last accepted key before a partial
//             entry is discarded (>=2)
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    teclado_clave_if slave modport (Tecla/TeclaValida in,
//          Clave/Enter/ErrorEntrada/Digitos out)
// -----------------------------------------------------------------------------
module teclado_clave #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  teclado_clave_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    REPOSO,
    FILTRO,
    SOSTENIDA
  } estado_t;

  estado_t       r_estado,  w_estado_nx;
  logic [CW-1:0] r_cnt,     w_cnt_nx;
  logic [3:0]    r_codigo,  w_codigo_nx;
  logic          w_acepta;
  logic [3:0]    w_tecla;

  logic [15:0]   r_buffer;
  logic [15:0]   r_clave;
  logic [2:0]    r_digitos;
  logic          r_enter;
  logic          r_error;
  logic [IW-1:0] r_idle;

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_estado <= REPOSO;
      r_cnt    <= '0;
      r_codigo <= '0;
    end else begin
      r_estado <= w_estado_nx;
      r_cnt    <= w_cnt_nx;
      r_codigo <= w_codigo_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state and acceptance strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    w_estado_nx = r_estado;
    w_cnt_nx    = r_cnt;
    w_codigo_nx = r_codigo;
    w_acepta    = 1'b0;
    w_tecla     = r_codigo;

    unique case (r_estado)
      REPOSO: begin
        if (bus.TeclaValida) begin
          w_codigo_nx = bus.Tecla;
          w_tecla     = bus.Tecla;
          if (DEBOUNCE == 1) begin
            // A single stable sample is already enough: act right away.
            w_acepta    = 1'b1;
            w_cnt_nx    = '0;
            w_estado_nx = SOSTENIDA;
          end else begin
            w_cnt_nx    = CW'(1);
            w_estado_nx = FILTRO;
          end
        end
      end

      FILTRO: begin
        if (!bus.TeclaValida || (bus.Tecla != r_codigo)) begin
          w_cnt_nx    = '0;
          w_estado_nx = REPOSO;
        end else if (r_cnt + CW'(1) == DEB_MAX) begin
          w_acepta    = 1'b1;
          w_cnt_nx    = '0;
          w_estado_nx = SOSTENIDA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      SOSTENIDA: begin
        // Key codes are ignored here; only a clean release lets us go back.
        if (bus.TeclaValida) begin
          w_cnt_nx = '0;
        end else if (r_cnt + CW'(1) == DEB_MAX) begin
          w_cnt_nx    = '0;
          w_estado_nx = REPOSO;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      default: begin
        w_cnt_nx    = '0;
        w_estado_nx = REPOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry datapath: key actions, idle timeout, registered outputs.
  // An acceptance takes priority over a timeout expiring on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_buffer  <= '0;
      r_clave   <= '0;
      r_digitos <= '0;
      r_enter   <= 1'b0;
      r_error   <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_enter <= 1'b0;
      r_error <= 1'b0;

      if (w_acepta) begin
        r_idle <= '0;
        if (w_tecla <= 4'h9) begin
          if (r_digitos != 3'd4) begin
            r_buffer  <= {r_buffer[11:0], w_tecla};
            r_digitos <= r_digitos + 3'd1;
          end else begin
            r_error <= 1'b1;
          end
        end else if (w_tecla == 4'hA) begin
          r_buffer  <= '0;
          r_digitos <= '0;
        end else if (w_tecla == 4'hB) begin
          if (r_digitos == 3'd4) begin
            r_clave <= r_buffer;
            r_enter <= 1'b1;
          end else begin
            r_error <= 1'b1;
          end
          r_buffer  <= '0;
          r_digitos <= '0;
        end else begin
          r_error <= 1'b1;
        end
      end else if (r_digitos != 3'd0) begin
        if (r_idle == IDLE_LAST) begin
          r_buffer  <= '0;
          r_digitos <= '0;
          r_error   <= 1'b1;
          r_idle    <= '0;
        end else begin
          r_idle <= r_idle + IW'(1);
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  assign bus.Clave        = r_clave;
  assign bus.Enter        = r_enter;
  assign bus.ErrorEntrada = r_error;
  assign bus.Digitos      = r_digitos;

endmodule

// File: tb/tb_teclado_clave.sv
// -----------------------------------------------------------------------------
// tb_teclado_clave
// Directed bench for teclado_clave (DEBOUNCE=4, TIMEOUT=50). Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same offset,
// so loop index i in press() is the i-th edge with the key sampled.
// -----------------------------------------------------------------------------
module tb_teclado_clave;

  localparam int DEB = 4;
  localparam int TMO = 50;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  always #5 Clk = ~Clk;

  teclado_clave_if bus ();

  teclado_clave #(
    .DEBOUNCE (DEB),
    .TIMEOUT  (TMO)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitors, sampled mid-cycle.
  int n_enter = 0;
  int n_err   = 0;
  int n_both  = 0;

  always @(negedge Clk) begin
    if (bus.Enter)                     n_enter++;
    if (bus.ErrorEntrada)              n_err++;
    if (bus.Enter && bus.ErrorEntrada) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold a key for 'hold' edges then release for 'rel' edges. Reports the
  // first edge index at which Digitos changed, Enter fired, ErrorEntrada fired
  // (-1 when it never happened).
  task automatic press(input logic [3:0] key, input int hold, input int rel,
                       output int dig_at, output int ent_at, output int err_at);
    logic [2:0] d0;
    d0     = bus.Digitos;
    dig_at = -1;
    ent_at = -1;
    err_at = -1;
    for (int i = 0; i < hold + rel; i++) begin
      bus.Tecla       = key;
      bus.TeclaValida = (i < hold);
      @(posedge Clk);
      #1;
      if (dig_at < 0 && bus.Digitos !== d0) dig_at = i;
      if (ent_at < 0 && bus.Enter)          ent_at = i;
      if (err_at < 0 && bus.ErrorEntrada)   err_at = i;
    end
    bus.TeclaValida = 1'b0;
  endtask

  // Released keypad for n edges; reports first edge (1-based) with ErrorEntrada.
  task automatic idle(input int n, output int err_at);
    err_at = -1;
    bus.TeclaValida = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge Clk);
      #1;
      if (err_at < 0 && bus.ErrorEntrada) err_at = i;
    end
  endtask

  // Digit press expected to be accepted with exp_dig digits afterwards.
  task automatic key_digit(input logic [3:0] key, input int exp_dig);
    int d, e, r;
    press(key, 6, 6, d, e, r);
    check($sformatf("dig%0h_latency", key), d, DEB - 1);
    check($sformatf("dig%0h_count", key), bus.Digitos, exp_dig);
    check($sformatf("dig%0h_noerr", key), r, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, e, r, t, err0, ent0;
    bus.Tecla       = 4'h0;
    bus.TeclaValida = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_clave",   bus.Clave, 16'h0000);
    check("rst_enter",   bus.Enter, 1'b0);
    check("rst_error",   bus.ErrorEntrada, 1'b0);
    check("rst_digitos", bus.Digitos, 3'd0);
    Reset = 1'b1;

    // Reset mid-entry while a key is being filtered
    key_digit(4'h1, 1);
    key_digit(4'h2, 2);
    bus.Tecla       = 4'h3;
    bus.TeclaValida = 1'b1;
    repeat (2) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("rst_async_digitos", bus.Digitos, 3'd0);
    check("rst_async_error",   bus.ErrorEntrada, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    // Key still held after release: needs a full filter sequence
    press(4'h3, 6, 6, d, e, r);
    check("held_after_rst_latency", d, DEB - 1);
    check("held_after_rst_digitos", bus.Digitos, 3'd1);
    press(4'hA, 6, 6, d, e, r);
    check("borrar1_digitos", bus.Digitos, 3'd0);
    check("borrar1_noerr",   r, -1);

    // 0,2,5,9 then Confirmar
    key_digit(4'h0, 1);
    key_digit(4'h2, 2);
    key_digit(4'h5, 3);
    key_digit(4'h9, 4);
    ent0 = n_enter;
    press(4'hB, 6, 6, d, e, r);
    check("conf_enter_at", e, DEB - 1);
    check("conf_noerr",    r, -1);
    check("conf_clave",    bus.Clave, 16'h0259);
    check("conf_digitos",  bus.Digitos, 3'd0);
    check("conf_one_pulse", n_enter - ent0, 1);

    // Glitch on key 7 then a clean hold
    err0 = n_err;
    ent0 = n_enter;
    for (int i = 0; i < 3; i++) begin
      bus.Tecla       = 4'h7;
      bus.TeclaValida = (i < 2);
      @(posedge Clk);
      #1;
    end
    check("glitch_digitos", bus.Digitos, 3'd0);
    press(4'h7, 20, 6, d, e, r);
    check("hold7_latency", d, DEB - 1);
    check("hold7_digitos", bus.Digitos, 3'd1);
    press(4'hA, 6, 6, d, e, r);
    check("borrar2_digitos", bus.Digitos, 3'd0);
    check("glitch_no_err",   n_err - err0, 0);
    check("glitch_no_enter", n_enter - ent0, 0);

    // Short entry then Confirmar
    key_digit(4'h1, 1);
    key_digit(4'h2, 2);
    press(4'hB, 6, 6, d, e, r);
    check("short_err_at",  r, DEB - 1);
    check("short_noenter", e, -1);
    check("short_clave",   bus.Clave, 16'h0259);
    check("short_digitos", bus.Digitos, 3'd0);

    // Fifth digit rejected; buffer must still hold 1234
    key_digit(4'h1, 1);
    key_digit(4'h2, 2);
    key_digit(4'h3, 3);
    key_digit(4'h4, 4);
    err0 = n_err;
    press(4'h5, 6, 6, d, e, r);
    check("fifth_err_at",    r, DEB - 1);
    check("fifth_one_pulse", n_err - err0, 1);
    check("fifth_digitos",   bus.Digitos, 3'd4);
    press(4'hB, 6, 6, d, e, r);
    check("fifth_conf_enter", e, DEB - 1);
    check("fifth_conf_clave", bus.Clave, 16'h1234);

    // Borrar, then invalid code 0xE with a digit buffered
    key_digit(4'h6, 1);
    press(4'hA, 6, 6, d, e, r);
    check("borrar3_digitos", bus.Digitos, 3'd0);
    key_digit(4'h6, 1);
    press(4'hE, 6, 6, d, e, r);
    check("inv_err_at",  r, DEB - 1);
    check("inv_digitos", bus.Digitos, 3'd1);
    check("inv_clave",   bus.Clave, 16'h1234);
    press(4'hA, 6, 6, d, e, r);

    // Timeout: accept at edge A, press ends at A+8, expiry at A+50 -> idle edge 42
    key_digit(4'h3, 1);
    idle(60, t);
    check("tmo_err_at",  t, TMO - 8);
    check("tmo_digitos", bus.Digitos, 3'd0);

    // Acceptance on the expiry edge wins
    key_digit(4'h3, 1);
    idle(TMO - 12, t);
    check("tmo_race_idle_noerr", t, -1);
    press(4'h4, 6, 6, d, e, r);
    check("tmo_race_latency", d, DEB - 1);
    check("tmo_race_noerr",   r, -1);
    check("tmo_race_digitos", bus.Digitos, 3'd2);
    idle(60, t);
    check("tmo2_err_at",  t, TMO - 8);
    check("tmo2_digitos", bus.Digitos, 3'd0);

    check("never_both",   n_both, 0);
    check("enter_total",  n_enter, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/teclado_clave.md
# teclado_clave

Keypad front end for the parking-lot access controller. It debounces keypad strobes and assembles four BCD digits into a 16-bit password. On confirmation it presents the password on `Clave` together with a one-cycle `Enter` pulse, the exact pair the `Controlador` block consumes. It also flags malformed or abandoned entries so the controller never sees partial passwords.

## Interface
- `DEBOUNCE`, default 4: consecutive sampled cycles a key must be stable before acceptance. Also used for release. Valid range is ≥1.
- `TIMEOUT`, default 1000: idle cycles after the last accepted key before a partial entry is discarded. Valid range is ≥2.
- `Clk`  in  1: single system clock. All logic updates on its rising edge.
- `Reset`  in  1: asynchronous, active-low reset. 0 resets the block immediately, independent of `Clk`.
- `Tecla`  in  4: key code from the keypad scanner. 0x0–0x9 are digits, 0xA is Borrar, 0xB is Confirmar, 0xC–0xF are invalid. Synchronous to `Clk`.
- `TeclaValida`  in  1: high while a key is pressed. Synchronous to `Clk`. May bounce.
- `Clave`  out  16: last confirmed password in BCD. The first digit typed sits in [15:12]. Registered.
- `Enter`  out  1: one-cycle pulse marking `Clave` as newly valid.
- `ErrorEntrada`  out  1: one-cycle pulse on a rejected key or a discarded entry.
- `Digitos`  out  3: number of digits currently buffered, 0–4.

## Operation
- Debounce FSM, three states:
  - REPOSO:
    - `TeclaValida`=1 → latch `Tecla`, set the counter to 1, go to FILTRO.
  - FILTRO:
    - `TeclaValida`=0 or `Tecla` ≠ latched code → go to REPOSO with no action.
    - Otherwise increment the counter.
    - The edge that brings the count to `DEBOUNCE` is the acceptance edge: perform the key action and go to SOSTENIDA.
    - With `DEBOUNCE`=1, acceptance happens on the REPOSO→FILTRO edge itself.
  - SOSTENIDA:
    - Stay until `TeclaValida` has been 0 for `DEBOUNCE` consecutive edges, then go to REPOSO.
    - A 1 during release restarts the release count.
    - A held key therefore produces exactly one action.
- Key actions, taken on the acceptance edge only:
  - Digit with `Digitos`<4: buffer <= {buffer[11:0], digit}, `Digitos`+1.
  - Digit with `Digitos`=4: buffer unchanged, `ErrorEntrada` pulses.
  - Borrar: buffer <= 0, `Digitos` <= 0, no pulse.
  - Confirmar with `Digitos`=4: `Clave` <= buffer, `Enter` pulses, buffer and `Digitos` cleared.
  - Confirmar with `Digitos`<4: buffer and `Digitos` cleared, `ErrorEntrada` pulses, `Clave` unchanged.
  - Code 0xC–0xF: nothing changes, `ErrorEntrada` pulses.
- Timeout:
  - The idle counter clears on every acceptance edge and counts while `Digitos`>0.
  - When it reaches `TIMEOUT`, the buffer and `Digitos` are cleared and `ErrorEntrada` pulses.
  - The counter holds at 0 while `Digitos`=0.
- `Clave` changes only on a successful Confirmar or on reset. It is stable between those events.

## Timing
- Reset values: state REPOSO, counters 0, buffer 0, `Clave`=16'h0000, `Enter`=0, `ErrorEntrada`=0, `Digitos`=0.
- Reset mid-entry discards the buffer immediately. After release, a key still held must complete a full REPOSO→FILTRO→acceptance sequence before it acts.
- Latency: `TeclaValida` first sampled high at edge N → action registered at edge N+`DEBOUNCE`−1.
  - `Enter`, `ErrorEntrada`, `Clave` and `Digitos` all change at that same edge, with no extra pipeline stage.
- `Enter` and `ErrorEntrada` are high for exactly one cycle and are never high together.
- Back-to-back keys: minimum spacing is 2×`DEBOUNCE` cycles (press filter plus release filter).
- Timeout expiry and an acceptance on the same edge: the acceptance wins. The key is processed, the idle counter clears, and there is no timeout pulse.
- Tecla change while in SOSTENIDA: ignored until release completes.

## Test plan
- Reset low mid-operation, then high → all outputs 0 asynchronously. State REPOSO. `Digitos`=0.
- `DEBOUNCE`=4. Keys 0,2,5,9 then Confirmar, each held 6 cycles with 6 cycles released → `Digitos` steps 1,2,3,4. `Clave`=16'h0259 and a single `Enter` pulse 3 edges after the Confirmar strobe is first sampled high. `Digitos` returns to 0.
- Key 7 with a 2-cycle glitch, then held 20 cycles → no action from the glitch, exactly one digit accepted, `Digitos`=1.
- Keys 1,2, then Confirmar → `ErrorEntrada` one pulse, no `Enter`, `Clave` keeps its previous value 16'h0259, `Digitos`=0.
- Keys 1,2,3,4,5 → fifth key produces an `ErrorEntrada` pulse and the buffer stays 1234. Then Borrar → `Digitos`=0. Then key 0xE → `ErrorEntrada` pulse and no change.
- `TIMEOUT`=50. Key 3, then idle → `ErrorEntrada` pulse at the 50th idle edge and `Digitos`=0. A repeat run with a key accepted exactly at the expiry edge → no pulse and `Digitos`=2.
